spi_slave: RTL and testbench

- SPI slave endpoint that sits directly downstream of the team's SPI master.
- Consumes the master's sck, ss and mosi lines and drives miso back to it.
- Supports all four CPOL/CPHA modes by oversampling the SPI pins in the system clock domain.
- Delivers each received word with a one-cycle valid strobe; accepts the next transmit word through a load/ready handshake.

---
 rtl/spi_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave endpoint. The SPI pins are oversampled in the clk domain, so
// all four CPOL/CPHA modes are handled by edge detection on the synchronised
// sck. Received words are presented with a one-cycle rx_valid strobe, and
// the next transmit word is accepted through a single-entry tx buffer.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [CW-1:0] IDX_MSB  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] IDX_PEN  = CW'(DATA_WIDTH - 2);
  localparam logic [CW-1:0] IDX_ZERO = CW'(0);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);

  // Synchroniser chains and the one-cycle-delayed copies used for edge detection
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   ss_prev_q;

  logic sck_s;
  logic ss_s;
  logic mosi_s;

  // Protocol state
  logic [0:0]            state_q,    state_d;
  logic                  cpol_q,     cpol_d;
  logic                  cpha_q,     cpha_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0]         tx_idx_q,   tx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]         bit_cnt_q,  bit_cnt_d;
  logic                  miso_q,     miso_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_buf_q,   tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;

  // Edge events and helpers
  logic                  lead_s;
  logic                  trail_s;
  logic                  sample_s;
  logic                  drive_s;
  logic                  ss_fall_s;
  logic                  ss_rise_s;
  logic                  consume_s;
  logic [DATA_WIDTH-1:0] next_word_s;
  logic [DATA_WIDTH-1:0] rx_word_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  // Classify sck transitions relative to the idle level latched at ss fall
  always_comb begin
    lead_s    = (sck_prev_q == cpol_q) && (sck_s != cpol_q);
    trail_s   = (sck_prev_q != cpol_q) && (sck_s == cpol_q);
    sample_s  = cpha_q ? trail_s : lead_s;
    drive_s   = cpha_q ? lead_s  : trail_s;
    ss_fall_s = ss_prev_q & ~ss_s;
    ss_rise_s = ~ss_prev_q & ss_s;
    // An empty buffer at word start transmits all zeros
    next_word_s = tx_ready_q ? {DATA_WIDTH{1'b0}} : tx_buf_q;
    rx_word_s   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  end

  // Next-state logic for the transfer FSM, shifters and tx buffer
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    consume_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_s) begin
          state_d    = ST_ACTIVE;
          cpol_d     = cpol;
          cpha_d     = cpha;
          tx_shift_d = next_word_s;
          consume_s  = 1'b1;
          bit_cnt_d  = IDX_ZERO;
          rx_shift_d = {DATA_WIDTH{1'b0}};
          if (cpha) begin
            tx_idx_d = IDX_MSB;
          end else begin
            // Leading edge samples, so the MSB must already be on the wire
            miso_d   = next_word_s[DATA_WIDTH-1];
            tx_idx_d = IDX_PEN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        if (ss_rise_s) begin
          // Abort: partial word dropped, consumed tx word is lost
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          bit_cnt_d  = IDX_ZERO;
          rx_shift_d = {DATA_WIDTH{1'b0}};
        end else begin
          if (drive_s) begin
            miso_d   = tx_shift_q[tx_idx_q];
            tx_idx_d = tx_idx_q - IDX_ONE;
          end else begin
            tx_idx_d = tx_idx_q;
          end
          if (sample_s) begin
            rx_shift_d = rx_word_s;
            if (bit_cnt_q == IDX_MSB) begin
              // Word complete; the next word starts with no gap
              rx_data_d  = rx_word_s;
              rx_valid_d = 1'b1;
              bit_cnt_d  = IDX_ZERO;
              tx_idx_d   = IDX_MSB;
              tx_shift_d = next_word_s;
              consume_s  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + IDX_ONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // A load in the same cycle as a word start lands after the start has
    // taken the (empty) buffer, so it is not lost
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end else if (consume_s) begin
      tx_ready_d = 1'b1;
    end else begin
      tx_ready_d = tx_ready_q;
    end
  end

  // Register all protocol state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= {DATA_WIDTH{1'b0}};
      tx_idx_q   <= IDX_ZERO;
      rx_shift_q <= {DATA_WIDTH{1'b0}};
      bit_cnt_q  <= IDX_ZERO;
      miso_q     <= 1'b0;
      rx_data_q  <= {DATA_WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      tx_buf_q   <= {DATA_WIDTH{1'b0}};
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a behavioural SPI master drives the pins while a
// word-level reference model predicts received words, transmitted words and
// tx buffer occupancy.
module tb_spi_slave;

  localparam int DW       = 8;
  localparam int CLK_HALF = 5;
  localparam int HALF     = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          sck = 1'b0;
  logic          ss = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [DW-1:0] tx_data = 8'h00;
  logic          tx_load = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;

  always #CLK_HALF clk = ~clk;

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpol     (cpol),
    .cpha     (cpha),
    .sck      (sck),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_tx_words [4];
  logic [7:0] m_rx_words [4];
  logic [7:0] rx_got [$];

  // Reference model state
  logic [7:0] mdl_buf     = 8'h00;
  bit         mdl_full    = 1'b0;
  logic [7:0] mdl_rx_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Collect every cycle rx_valid is high; a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (!rst && rx_valid) rx_got.push_back(rx_data);
  end

  task automatic load_word(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!mdl_full) begin
      mdl_buf  = v;
      mdl_full = 1'b1;
    end
  endtask

  function automatic logic mbit(input int k);
    logic [7:0] w;
    w = m_tx_words[k/8];
    return w[7-(k%8)];
  endfunction

  // Behavioural SPI master: MSB first, mosi changes on the drive edge, miso read on the sample edge
  task automatic master(input logic p, input logic h, input int nbits);
    cpol = p;
    cpha = h;
    sck  = p;
    mosi = h ? 1'b0 : mbit(0);
    #HALF;
    ss = 1'b0;
    #HALF;
    for (int k = 0; k < nbits; k++) begin
      if (!h) begin
        m_rx_words[k/8][7-(k%8)] = miso;
        sck = ~p;
        #HALF;
        sck = p;
        if (k + 1 < nbits) mosi = mbit(k + 1);
        #HALF;
      end else begin
        sck  = ~p;
        mosi = mbit(k);
        #HALF;
        m_rx_words[k/8][7-(k%8)] = miso;
        sck = p;
        #HALF;
      end
    end
    ss = 1'b1;
    #(2*HALF);
  endtask

  task automatic run_xfer(input string tag, input logic p, input logic h, input int nbits,
                          input bit do_pre, input logic [7:0] pre,
                          input bit do_mid, input logic [7:0] mid);
    int f;
    logic [7:0] exp_miso [5];
    f = nbits / 8;
    if (do_pre) load_word(pre);
    chk({tag, ":tx_ready_pre"}, {31'd0, tx_ready}, {31'd0, !mdl_full});
    rx_got.delete();
    // First word start happens at ss fall
    exp_miso[0] = mdl_full ? mdl_buf : 8'h00;
    mdl_full = 1'b0;
    fork
      master(p, h, nbits);
      begin
        #(HALF*5/2);
        chk({tag, ":busy_active"}, {31'd0, busy}, 32'd1);
        chk({tag, ":tx_ready_after_fall"}, {31'd0, tx_ready}, 32'd1);
        if (do_mid) begin
          #(HALF*2);
          load_word(mid);
        end
      end
    join
    // Each completed word starts another one
    for (int i = 1; i <= f; i++) begin
      exp_miso[i] = mdl_full ? mdl_buf : 8'h00;
      mdl_full = 1'b0;
    end
    chk({tag, ":rx_count"}, rx_got.size(), f);
    for (int i = 0; i < f; i++) begin
      chk($sformatf("%s:rx_word%0d", tag, i), {24'd0, rx_got[i]}, {24'd0, m_tx_words[i]});
      chk($sformatf("%s:miso_word%0d", tag, i), {24'd0, m_rx_words[i]}, {24'd0, exp_miso[i]});
    end
    if (f > 0) mdl_rx_data = m_tx_words[f-1];
    chk({tag, ":rx_data_hold"}, {24'd0, rx_data}, {24'd0, mdl_rx_data});
    chk({tag, ":busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ":miso_idle"}, {31'd0, miso}, 32'd0);
    chk({tag, ":tx_ready_post"}, {31'd0, tx_ready}, {31'd0, !mdl_full});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #25;
    chk("reset:miso", {31'd0, miso}, 32'd0);
    chk("reset:rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset:rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset:busy", {31'd0, busy}, 32'd0);
    chk("reset:tx_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b0;
    #(4*HALF);

    m_tx_words[0] = 8'hA5;
    run_xfer("mode0", 1'b0, 1'b0, 8, 1'b1, 8'h3C, 1'b0, 8'h00);

    for (int m = 1; m < 4; m++) begin
      logic [1:0] mm;
      mm = 2'(m);
      m_tx_words[0] = 8'h5A;
      run_xfer($sformatf("mode%0d", m), mm[1], mm[0], 8, 1'b1, 8'hC3, 1'b0, 8'h00);
    end

    m_tx_words[0] = 8'hF0;
    m_tx_words[1] = 8'h0F;
    run_xfer("b2b", 1'b0, 1'b0, 16, 1'b1, 8'h11, 1'b1, 8'h22);

    m_tx_words[0] = 8'h81;
    run_xfer("noload", 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0, 8'h00);

    m_tx_words[0] = 8'hFF;
    run_xfer("abort", 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b0, 8'h00);
    m_tx_words[0] = 8'h96;
    run_xfer("after_abort", 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a word with a loaded buffer
    m_tx_words[0] = 8'h55;
    fork
      master(1'b0, 1'b0, 8);
      begin
        #(HALF*3);
        load_word(8'h77);
        #(HALF*2 + 3);
        rst = 1'b1;
        #1;
        chk("midrst:miso", {31'd0, miso}, 32'd0);
        chk("midrst:rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst:rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst:busy", {31'd0, busy}, 32'd0);
        chk("midrst:tx_ready", {31'd0, tx_ready}, 32'd1);
      end
    join
    #HALF;
    rst = 1'b0;
    mdl_full    = 1'b0;
    mdl_rx_data = 8'h00;
    rx_got.delete();
    #(2*HALF);
    m_tx_words[0] = 8'h3C;
    run_xfer("post_rst", 1'b0, 1'b0, 8, 1'b1, 8'h3C, 1'b0, 8'h00);

    // Randomised transfers: mode, word count, trailing partial word, buffer loads
    for (int it = 0; it < 16; it++) begin
      int nw;
      int nb;
      bit pre_en;
      bit mid_en;
      nw = int'($urandom_range(1, 3));
      nb = nw * 8;
      if ($urandom_range(0, 3) == 0) nb = nb + int'($urandom_range(1, 7));
      for (int w = 0; w < 4; w++) m_tx_words[w] = 8'($urandom);
      pre_en = 1'($urandom_range(0, 1));
      mid_en = 1'($urandom_range(0, 1));
      run_xfer($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               nb, pre_en, 8'($urandom), mid_en, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
